// File: rtl/seq_serializer_if.sv
// Parallel-word handshake and serial bit-stream bundle for seq_serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, word_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, word_done
  );
endinterface

// File: rtl/seq_serializer.sv
// Word-to-bit serializer with a one-entry holding buffer for gapless back-to-back words.
// Optional even-parity bit per word when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            reset,
  seq_serializer_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             load, accept, word_end;
  logic             x_r, x_n, xv_r, xv_n, wd_r, wd_n;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             par_r, par_n;
`endif

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept = bus.din_valid & ~hold_full;

  // Next-state: outputs are computed for the cycle after the edge, so x is a flop.
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    load        = 1'b0;
    load_word   = bus.din;
    x_n         = 1'b1;
    xv_n        = 1'b0;
    wd_n        = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    par_n       = par_r;
    word_end    = (state == PAR);
`else
    word_end    = (state == SHIFT) && (cnt == LAST_IDX);
`endif
    case (state)
      IDLE: load = accept;
      default: begin
        if (word_end) begin
          // A waiting word (held, or arriving right now) starts with no idle gap.
          if (hold_full) begin
            load        = 1'b1;
            load_word   = hold;
            hold_full_n = 1'b0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (accept) begin
            hold_n      = bus.din;
            hold_full_n = 1'b1;
          end
          xv_n = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
          if (cnt == LAST_IDX) begin
            state_n = PAR;
            x_n     = par_r;
            wd_n    = 1'b1;
          end else begin
            cnt_n  = cnt + CW'(1);
            sreg_n = advance(sreg);
            x_n    = lead_bit(sreg_n);
          end
`else
          cnt_n  = cnt + CW'(1);
          sreg_n = advance(sreg);
          x_n    = lead_bit(sreg_n);
          wd_n   = (cnt_n == LAST_IDX);
`endif
        end
      end
    endcase
    if (load) begin
      state_n = SHIFT;
      sreg_n  = load_word;
      cnt_n   = '0;
      x_n     = lead_bit(load_word);
      xv_n    = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_n   = ^load_word;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      x_r       <= 1'b1;
      xv_r      <= 1'b0;
      wd_r      <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      x_r       <= x_n;
      xv_r      <= xv_n;
      wd_r      <= wd_n;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_r     <= par_n;
`endif
    end
  end

  assign bus.din_ready = ~hold_full;
  assign bus.x         = x_r;
  assign bus.x_valid   = xv_r;
  assign bus.word_done = wd_r;
  assign bus.busy      = (state != IDLE) | hold_full;
endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers against a bit-queue reference model.
module tb_seq_serializer;
  localparam int W = 8;
`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BITS = W + PAR;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  ent_t mq [2][$];
  int   run [2];
  int   last_run [2];
  logic last_acc;

  seq_serializer_if #(.WIDTH(W)) b0 ();
  seq_serializer_if #(.WIDTH(W)) b1 ();

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  seq_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] d);
    b0.din = d; b0.din_valid = v;
    b1.din = d; b1.din_valid = v;
  endtask

  // Expected stream of one word: data bits in the DUT's order, then optional even parity.
  task automatic push_word(input int k, input logic [W-1:0] w);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.b     = (k == 0) ? w[W-1-i] : w[i];
      e.first = (i == 0);
      e.last  = (i == W - 1) && (PAR == 0);
      mq[k].push_back(e);
    end
    if (PAR != 0) begin
      e.b = ^w; e.first = 1'b0; e.last = 1'b1;
      mq[k].push_back(e);
    end
  endtask

  task automatic monitor(input int k, input logic x, input logic xv, input logic wd,
                         input logic rdy, input logic busy);
    ent_t  e;
    logic  exp_v;
    logic  pend;
    string p;
    p     = (k == 0) ? "msb" : "lsb";
    exp_v = (mq[k].size() != 0);
    chk1({p, ".x_valid"}, xv, exp_v);
    chk1({p, ".busy"}, busy, exp_v);
    if (exp_v) begin
      e = mq[k].pop_front();
      chk1({p, ".x"}, x, e.b);
      chk1({p, ".word_done"}, wd, e.last);
    end else begin
      chk1({p, ".x_idle"}, x, 1'b1);
      chk1({p, ".word_done_idle"}, wd, 1'b0);
    end
    // Any not-yet-started word still queued must be sitting in the holding buffer.
    pend = 1'b0;
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i].first) pend = 1'b1;
    chk1({p, ".din_ready"}, rdy, ~pend);
    if (xv) run[k]++;
    else begin
      if (run[k] != 0) last_run[k] = run[k];
      run[k] = 0;
    end
  endtask

  task automatic tick();
    logic a0, a1;
    a0 = b0.din_valid && b0.din_ready;
    a1 = b1.din_valid && b1.din_ready;
    if (a0) push_word(0, b0.din);
    if (a1) push_word(1, b1.din);
    last_acc = a0;
    @(posedge clk);
    @(negedge clk);
    monitor(0, b0.x, b0.x_valid, b0.word_done, b0.din_ready, b0.busy);
    monitor(1, b1.x, b1.x_valid, b1.word_done, b1.din_ready, b1.busy);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    set_in(1'b0, '0);
    while ((mq[0].size() != 0 || mq[1].size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk1({tag, ".drain_budget"}, n < 100, 1'b1);
    tick();
    tick();
  endtask

  task automatic stream(input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input logic [W-1:0] w2, input int nw, input string tag);
    logic [W-1:0] wl [$];
    int guard = 0;
    wl.push_back(w0);
    if (nw > 1) wl.push_back(w1);
    if (nw > 2) wl.push_back(w2);
    while (wl.size() != 0 && guard < 100) begin
      set_in(1'b1, wl[0]);
      tick();
      if (last_acc) void'(wl.pop_front());
      guard++;
    end
    chk1({tag, ".accept_budget"}, guard < 100, 1'b1);
    drain(tag);
    chk({tag, ".msb_run_len"}, last_run[0], nw * BITS);
    chk({tag, ".lsb_run_len"}, last_run[1], nw * BITS);
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, ".msb_x"}, b0.x, 1'b1);
    chk1({tag, ".msb_x_valid"}, b0.x_valid, 1'b0);
    chk1({tag, ".msb_din_ready"}, b0.din_ready, 1'b1);
    chk1({tag, ".msb_busy"}, b0.busy, 1'b0);
    chk1({tag, ".msb_word_done"}, b0.word_done, 1'b0);
    chk1({tag, ".lsb_x"}, b1.x, 1'b1);
    chk1({tag, ".lsb_x_valid"}, b1.x_valid, 1'b0);
    chk1({tag, ".lsb_din_ready"}, b1.din_ready, 1'b1);
    chk1({tag, ".lsb_busy"}, b1.busy, 1'b0);
    chk1({tag, ".lsb_word_done"}, b1.word_done, 1'b0);
  endtask

  initial begin
    set_in(1'b0, '0);
    run[0] = 0; run[1] = 0; last_run[0] = 0; last_run[1] = 0;
    @(negedge clk);
    chk_idle("reset_state");
    reset = 1'b0;
    tick();

    stream(8'h60, 8'h00, 8'h00, 1, "single_60");
    stream(8'hA5, 8'h3C, 8'h5A, 3, "backtoback");
    stream(8'h06, 8'h00, 8'h00, 1, "single_06");
    stream(8'h07, 8'h00, 8'h00, 1, "single_07");
    stream(8'hB4, 8'h00, 8'h00, 1, "single_b4");

    // Reset mid-word with a buffered word pending; neither may reappear.
    set_in(1'b1, 8'hFF); tick();
    set_in(1'b1, 8'h81); tick();
    set_in(1'b0, '0);    tick();
    #2 reset = 1'b1;
    #1 chk_idle("async_reset");
    mq[0].delete(); mq[1].delete();
    run[0] = 0; run[1] = 0;
    @(negedge clk);
    reset = 1'b0;
    chk1("post_reset.din_ready", b0.din_ready, 1'b1);
    set_in(1'b1, 8'h3C);
    tick();
    chk1("post_reset.first_accept", last_acc, 1'b1);
    drain("post_reset");
    chk("post_reset.run_len", last_run[0], BITS);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 99) < 60, W'($urandom));
      tick();
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word offered for transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  registered serial bit stream feeding the sequence recognizer.
REQ-009 x_valid  output  1  x carries a data or parity bit this cycle.
REQ-010 busy  output  1  state is not IDLE or the holding buffer is full.
REQ-011 word_done  output  1  one-cycle pulse while the final bit of a word (data or parity) is on x.

Function
REQ-012 A transfer SHALL occur at a posedge where din_valid=1 and din_ready=1; din SHALL be ignored at all other edges.
REQ-013 The block SHALL contain a WIDTH-bit shift register, a bit counter, and a one-entry holding buffer; din_ready SHALL equal NOT hold_full, registered.
REQ-014 The FSM SHALL have states IDLE, SHIFT, and PAR (PAR only when parity is compiled in).
REQ-015 IDLE: x=1, x_valid=0; an accepted word SHALL load the shift register directly (bypassing the hold), clear the counter, and enter SHIFT at that edge.
REQ-016 SHIFT: x SHALL present one bit per cycle in the MSB_FIRST order, x_valid=1, for exactly WIDTH cycles; the first bit SHALL appear in the cycle after the accepting edge.
REQ-017 SHIFT, accept while in SHIFT or PAR: the word SHALL be written to the holding buffer and hold_full set.
REQ-018 At the end of the last data bit: with parity compiled in, go to PAR; otherwise, if hold_full, move hold to the shift register, clear hold_full, and remain in SHIFT with no idle gap; otherwise go to IDLE.
REQ-019 PAR: x=even-parity bit (XOR of all WIDTH data bits), x_valid=1, one cycle; then reload from the hold as in REQ-018, or go to IDLE.
REQ-020 While hold_full=1, din_ready SHALL be 0 even on the edge where the hold drains; a new accept SHALL be possible at the next edge.
REQ-021 word_done SHALL be high exactly one cycle per word, aligned with the final bit on x.
REQ-022 The x idle level SHALL be 1, so that a downstream recognizer sees a constant 1 between words.
REQ-023 busy SHALL be 0 only when state=IDLE and hold_full=0.

Reset
REQ-024 reset=1 SHALL immediately, independent of clk, force state=IDLE, x=1, x_valid=0, word_done=0, hold_full=0, din_ready=1, busy=0, and clear the counter and shift register.
REQ-025 A reset mid-word SHALL discard both the in-flight and the buffered word; no partial word SHALL resume after reset.
REQ-026 The first accept after reset release SHALL be possible at the first posedge where reset=0.

Configuration
REQ-027 Macro SEQ_SERIALIZER_PARITY_EN: defined, the PAR state exists and each word occupies WIDTH+1 x_valid cycles ending with the even-parity bit.
REQ-028 Without SEQ_SERIALIZER_PARITY_EN, the PAR state and parity logic SHALL be absent and each word occupies exactly WIDTH x_valid cycles.

Verification
REQ-029 Default parameters, no parity, din=8'b0110_0000 accepted once -> x=0,1,1,0,0,0,0,0 on 8 consecutive cycles with x_valid=1; word_done on the 8th cycle; then x=1, x_valid=0, busy=0.
REQ-030 Words 8'hA5 then 8'h3C, with din_valid held continuously -> 16 consecutive x_valid cycles, no gap; din_ready=0 from the second accept until the hold drains.
REQ-031 Backpressure: din_valid=1 throughout with a third word while the hold is full -> din_ready=0; the third word is sent intact after the second, with no loss and no duplication.
REQ-032 reset asserted during bit 3 of 8'hFF, with a buffered word pending -> x=1, x_valid=0, din_ready=1 without a clock edge; after release, no remaining bits are emitted.
REQ-033 SEQ_SERIALIZER_PARITY_EN defined: din=8'h07 -> 9 valid bits ending with parity bit 1; din=8'hB4 -> parity bit 0; word_done on the 9th bit.
REQ-034 MSB_FIRST=0, din=8'h06 -> x=0,1,1,0,0,0,0,0 (LSB first).
